// File: rtl/adc5g_gray_decode_pipe_if.sv
// rtl/adc5g_gray_decode_pipe_if.sv - sample/result bundle for the Gray decode pipeline
interface adc5g_gray_decode_pipe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4
);
  logic                         din_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] din;
  logic                         sync_in;
  logic                         gray_en;
  logic                         dout_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] dout;
  logic                         sync_out;
  logic [NUM_CH-1:0]            ovr;

  modport master (
    output din_valid, din, sync_in, gray_en,
    input  dout_valid, dout, sync_out, ovr
  );

  modport slave (
    input  din_valid, din, sync_in, gray_en,
    output dout_valid, dout, sync_out, ovr
  );
endinterface

// File: rtl/adc5g_gray_decode_pipe.sv
// rtl/adc5g_gray_decode_pipe.sv - pipelined multi-channel Gray decoder; ADC5G_GRAY_DECODE_STATS_EN adds overrange counters
module adc5g_gray_decode_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TWOS_COMP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adc5g_gray_decode_pipe_if.slave  bus,
  input  logic                     clr_stats,
  output logic [NUM_CH*16-1:0]     ovr_count
);
  localparam int DW = DATA_WIDTH;
  localparam int NW = NUM_CH * DATA_WIDTH;

  // Resolves bits hi..lo of the XOR prefix chain; bits above hi are already binary.
  function automatic logic [DW-1:0] decode_slice(input logic [DW-1:0] w, input int hi, input int lo);
    logic [DW-1:0] r;
    r = w;
    for (int i = DW - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) r[i] = r[i+1] ^ w[i];
    end
    return r;
  endfunction

  logic [NW-1:0]          stg_data  [PIPE_STAGES];
  logic                   stg_valid [PIPE_STAGES];
  logic                   stg_gray  [PIPE_STAGES];
  logic [NW-1:0]          dout_q;
  logic                   dout_valid_q;
  logic [NUM_CH-1:0]      ovr_q;
  logic [PIPE_STAGES-1:0] sync_q;

  assign stg_data[0]    = bus.din;
  assign stg_valid[0]   = bus.din_valid;
  assign stg_gray[0]    = bus.gray_en;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.ovr        = ovr_q;
  assign bus.sync_out   = sync_q[PIPE_STAGES-1];

  // Sync is a plain delay line, deliberately not gated by valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.sync_in;
      for (int i = 1; i < PIPE_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int HI = DW - 1 - (s * DW) / PIPE_STAGES;
    localparam int LO = DW - ((s + 1) * DW) / PIPE_STAGES;
    logic [NW-1:0] dec;

    // Decode this stage's MSB-first slice of every channel unless the sample was taken in pass-through mode.
    always_comb begin
      dec = stg_data[s];
      if (stg_gray[s]) begin
        for (int c = 0; c < NUM_CH; c++) dec[c*DW +: DW] = decode_slice(stg_data[s][c*DW +: DW], HI, LO);
      end
    end

    if (s < PIPE_STAGES - 1) begin : g_mid
      logic [NW-1:0] data_q;
      logic          valid_q;
      logic          gray_q;

      // Intermediate stage: partial binary on top, untouched Gray below, mode bit carried along.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
          gray_q  <= 1'b0;
        end else begin
          data_q  <= dec;
          valid_q <= stg_valid[s];
          gray_q  <= stg_gray[s];
        end
      end

      assign stg_data[s+1]  = data_q;
      assign stg_valid[s+1] = valid_q;
      assign stg_gray[s+1]  = gray_q;
    end else begin : g_last
      logic [NW-1:0]     fmt;
      logic [NUM_CH-1:0] ovr_d;

      // Overrange looks at the unformatted binary; the MSB flip for two's complement comes after.
      always_comb begin
        fmt   = dec;
        ovr_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          ovr_d[c] = (&dec[c*DW +: DW]) | ~(|dec[c*DW +: DW]);
          if (TWOS_COMP != 0) fmt[c*DW + DW - 1] = ~dec[c*DW + DW - 1];
        end
      end

      // Output register holds the last word across bubbles; ovr only reads high alongside dout_valid.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
          ovr_q        <= '0;
        end else begin
          dout_valid_q <= stg_valid[s];
          ovr_q        <= stg_valid[s] ? ovr_d : '0;
          if (stg_valid[s]) dout_q <= fmt;
        end
      end
    end
  end

`ifdef ADC5G_GRAY_DECODE_STATS_EN
  logic [15:0] cnt_q [NUM_CH];

  // Saturating per-channel overrange counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n || clr_stats) begin
        cnt_q[c] <= '0;
      end else if (ovr_q[c] && cnt_q[c] != 16'hFFFF) begin
        cnt_q[c] <= cnt_q[c] + 16'd1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    assign ovr_count[c*16 +: 16] = cnt_q[c];
  end
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign ovr_count        = '0;
`endif
endmodule

// File: tb/tb_adc5g_gray_decode_pipe.sv
// tb/tb_adc5g_gray_decode_pipe.sv - scoreboard bench over several pipeline depths and output formats
module tb_adc5g_gray_decode_pipe;
  localparam int NI = 5;

  function automatic int ps_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int tc_of(input int k);
    return (k == 4) ? 1 : 0;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [3:0]  ovr;
    int          kat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din_valid;
  logic [31:0] din;
  logic        sync_in;
  logic        gray_en;
  logic        clr_stats;

  logic [31:0] o_dout  [NI];
  logic        o_valid [NI];
  logic        o_sync  [NI];
  logic [3:0]  o_ovr   [NI];
  logic [63:0] o_cnt   [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_inst
    adc5g_gray_decode_pipe_if #(.DATA_WIDTH(8), .NUM_CH(4)) bus ();
    assign bus.din_valid = din_valid;
    assign bus.din       = din;
    assign bus.sync_in   = sync_in;
    assign bus.gray_en   = gray_en;
    assign o_dout[k]     = bus.dout;
    assign o_valid[k]    = bus.dout_valid;
    assign o_sync[k]     = bus.sync_out;
    assign o_ovr[k]      = bus.ovr;

    adc5g_gray_decode_pipe #(
      .DATA_WIDTH(8), .NUM_CH(4), .PIPE_STAGES(ps_of(k)), .TWOS_COMP(tc_of(k))
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .clr_stats(clr_stats), .ovr_count(o_cnt[k])
    );
  end

  // Reference: binary is the XOR of the Gray word with every right shift of itself.
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rst = 0;
  logic hv [16];
  logic hs [16];
  logic hc [16];
  exp_t q [NI][$];

  task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d edge=%0d got=%0h exp=%0h", name, k, cyc - 1, got, exp);
    end
  endtask

  // Recorder: samples stimulus at each edge and pushes the expected result for every instance.
  exp_t xr;
  logic [7:0] br;
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      last_rst = cyc;
      hv[cyc % 16] = 1'b0;
      hs[cyc % 16] = 1'b0;
      hc[cyc % 16] = 1'b0;
      for (int k = 0; k < NI; k++) q[k].delete();
    end else begin
      hv[cyc % 16] = din_valid;
      hs[cyc % 16] = sync_in;
      hc[cyc % 16] = clr_stats;
      if (din_valid) begin
        for (int k = 0; k < NI; k++) begin
          xr.due = cyc + ps_of(k) - 1;
          xr.kat = (gray_en && din == 32'hFFC00180) ? 1 : 0;
          for (int c = 0; c < 4; c++) begin
            br = gray_en ? g2b(din[c*8 +: 8]) : din[c*8 +: 8];
            xr.ovr[c] = (br == 8'h00) || (br == 8'hFF);
            xr.data[c*8 +: 8] = (tc_of(k) != 0) ? (br ^ 8'h80) : br;
          end
          q[k].push_back(xr);
        end
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: checks every instance shortly after each edge.
  exp_t xm;
  int e_m, src;
  logic ev, es;
  logic [31:0] last_dout [NI];
  logic [3:0]  prev_ovr  [NI];
  logic [3:0]  cur_ovr;
  logic [15:0] cnt_m [NI][4];
  logic [63:0] ce;
  initial forever begin
    @(posedge clk);
    #1;
    e_m = cyc - 1;
    for (int k = 0; k < NI; k++) begin
      if (e_m == last_rst) begin
        last_dout[k] = '0;
        prev_ovr[k]  = '0;
      end
      src = e_m - ps_of(k) + 1;
      ev  = (src > last_rst) ? hv[src % 16] : 1'b0;
      es  = (src > last_rst) ? hs[src % 16] : 1'b0;
      check("dout_valid", k, 64'(o_valid[k]), 64'(ev));
      check("sync_out", k, 64'(o_sync[k]), 64'(es));
      cur_ovr = '0;
      if (o_valid[k]) begin
        if (q[k].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output inst=%0d edge=%0d got=%0h exp=none", k, e_m, o_dout[k]);
        end else begin
          xm = q[k].pop_front();
          check("latency", k, 64'(e_m), 64'(xm.due));
          check("dout", k, 64'(o_dout[k]), 64'(xm.data));
          check("ovr", k, 64'(o_ovr[k]), 64'(xm.ovr));
          if (xm.kat != 0) begin
            check("known_vector_dout", k, 64'(o_dout[k]), (tc_of(k) != 0) ? 64'h2A00817F : 64'hAA8001FF);
            check("known_vector_ovr", k, 64'(o_ovr[k]), 64'h1);
          end
          cur_ovr = xm.ovr;
        end
        last_dout[k] = o_dout[k];
      end else begin
        check("ovr_idle", k, 64'(o_ovr[k]), 64'h0);
        check("dout_hold", k, 64'(o_dout[k]), 64'(last_dout[k]));
      end
      ce = '0;
      for (int c = 0; c < 4; c++) begin
        if (e_m == last_rst || hc[e_m % 16]) cnt_m[k][c] = 16'h0;
        else if (prev_ovr[k][c] && cnt_m[k][c] != 16'hFFFF) cnt_m[k][c] = cnt_m[k][c] + 16'd1;
`ifdef ADC5G_GRAY_DECODE_STATS_EN
        ce[c*16 +: 16] = cnt_m[k][c];
`endif
      end
      check("ovr_count", k, o_cnt[k], ce);
      prev_ovr[k] = cur_ovr;
    end
  end

  // Stimulus
  logic g_tog;
  int   ch;
  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din = '0; sync_in = 1'b0; gray_en = 1'b0; clr_stats = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = $urandom; din_valid = i[0]; sync_in = ~i[0]; gray_en = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1; din_valid = 1'b0; sync_in = 1'b0; din = $urandom;

    @(negedge clk);
    din = 32'hFFC00180; din_valid = 1'b1; gray_en = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (10) @(negedge clk);

    g_tog = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din_valid = (i % 2 == 0);
      sync_in   = (i == 0);
      if (i % 2 == 0) g_tog = ~g_tog;
      gray_en = g_tog;
      din = $urandom;
      @(negedge clk);
    end
    din_valid = 1'b0; sync_in = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      rst_n     = (i != 300);
      din_valid = ($urandom_range(0, 3) != 0);
      sync_in   = ($urandom_range(0, 7) == 0);
      gray_en   = $urandom_range(0, 1) != 0;
      clr_stats = ($urandom_range(0, 15) == 0);
      din       = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        ch = $urandom_range(0, 3);
        din[ch*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00;
      end
      @(negedge clk);
    end
    rst_n = 1'b1; clr_stats = 1'b0;

`ifdef ADC5G_GRAY_DECODE_STATS_EN
    clr_stats = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    clr_stats = 1'b0; din_valid = 1'b1; gray_en = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      din = {$urandom_range(1, 126) > 0 ? 8'h11 : 8'h12, 8'h22, 8'h33, 8'h80};
      @(negedge clk);
    end
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    repeat (4) @(negedge clk);
`endif

    din_valid = 1'b0; sync_in = 1'b0;
    repeat (12) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
